ifstage_fetch: RTL

Instruction fetch stage of the multi-cycle processor: holds the PC, fetches one instruction word per load request from a handshaked instruction memory, and presents it on `Instr` to the control unit. The control unit consumes `Instr` and drives `PC_sel`/`PC_LdEn` back into this block to select sequential or branch-target next PC. A wait-state timeout guards against a non-responding memory.

---
 rtl/ifstage_fetch_if.sv | 26 ++
 rtl/ifstage_fetch.sv | 132 +++++++++++++
 2 files changed

// File: rtl/ifstage_fetch_if.sv
// Instruction-memory handshake bundle between the fetch stage and the IMEM.
//   IMEM_Req  : fetch request, held until ack or timeout
//   IMEM_Addr : word-aligned byte address being fetched
//   IMEM_Ack  : memory response valid
//   IMEM_Data : instruction word, valid with IMEM_Ack
// master = fetch stage, slave = instruction memory.
interface ifstage_fetch_if;
    logic        IMEM_Req;
    logic [31:0] IMEM_Addr;
    logic        IMEM_Ack;
    logic [31:0] IMEM_Data;

    modport master (
        output IMEM_Req,
        output IMEM_Addr,
        input  IMEM_Ack,
        input  IMEM_Data
    );

    modport slave (
        input  IMEM_Req,
        input  IMEM_Addr,
        output IMEM_Ack,
        output IMEM_Data
    );
endinterface

// File: rtl/ifstage_fetch.sv
// Instruction fetch stage of the multi-cycle processor. Holds the PC, fetches
// one word per load request over the IMEM handshake and presents it on Instr.
// A wait-state counter aborts and re-issues a fetch the memory never answers.
//   Clk, Reset     : rising-edge clock, asynchronous active-high reset
//   PC_sel         : 0 = PC+4, 1 = PC+4+(PC_Immed<<2)
//   PC_LdEn        : load-next-PC request, acted on only in HOLD
//   PC_Immed       : sign-extended word offset
//   imem           : instruction memory handshake (master side)
//   PC             : address of current/in-flight instruction
//   Instr          : last fetched instruction
//   Instr_Valid    : Instr belongs to PC and is stable
//   Fetch_Timeout  : one-cycle pulse when a fetch is abandoned
module ifstage_fetch #(
    parameter logic [31:0]  RESET_PC = 32'h0000_0000,
    parameter int unsigned  MAX_WAIT = 15
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic                   PC_sel,
    input  logic                   PC_LdEn,
    input  logic [31:0]            PC_Immed,
    ifstage_fetch_if.master        imem,
    output logic [31:0]            PC,
    output logic [31:0]            Instr,
    output logic                   Instr_Valid,
    output logic                   Fetch_Timeout
);

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(MAX_WAIT - 1);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_WAIT  = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [31:0]      pc_q, pc_nxt;
    logic [31:0]      instr_q, instr_nxt;
    logic             valid_q, valid_nxt;
    logic             req_q, req_nxt;
    logic [31:0]      addr_q, addr_nxt;
    logic             tmo_q, tmo_nxt;
    logic [CNT_W-1:0] wcnt_q, wcnt_nxt;
    logic [31:0]      next_pc;

    // Sequential or branch target; the shift drops the immediate's top two bits.
    assign next_pc = pc_q + 32'd4 + (PC_sel ? (PC_Immed << 2) : 32'd0);

    // State and output registers
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state   <= S_FETCH;
            pc_q    <= RESET_PC;
            instr_q <= 32'h0;
            valid_q <= 1'b0;
            req_q   <= 1'b0;
            addr_q  <= RESET_PC;
            tmo_q   <= 1'b0;
            wcnt_q  <= '0;
        end else begin
            state   <= state_nxt;
            pc_q    <= pc_nxt;
            instr_q <= instr_nxt;
            valid_q <= valid_nxt;
            req_q   <= req_nxt;
            addr_q  <= addr_nxt;
            tmo_q   <= tmo_nxt;
            wcnt_q  <= wcnt_nxt;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc_q;
        instr_nxt = instr_q;
        valid_nxt = valid_q;
        req_nxt   = req_q;
        addr_nxt  = addr_q;
        tmo_nxt   = 1'b0;
        wcnt_nxt  = wcnt_q;

        unique case (state)
            S_FETCH: begin
                req_nxt   = 1'b1;
                addr_nxt  = pc_q;
                wcnt_nxt  = '0;
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                // An ack arriving on the would-be timeout edge still wins.
                if (imem.IMEM_Ack) begin
                    instr_nxt = imem.IMEM_Data;
                    valid_nxt = 1'b1;
                    req_nxt   = 1'b0;
                    state_nxt = S_HOLD;
                end else if (wcnt_q == LAST_WAIT) begin
                    req_nxt   = 1'b0;
                    tmo_nxt   = 1'b1;
                    wcnt_nxt  = '0;
                    state_nxt = S_FETCH;
                end else begin
                    wcnt_nxt  = wcnt_q + CNT_W'(1);
                end
            end
            S_HOLD: begin
                // Issue the next fetch directly; skipping FETCH saves a cycle.
                if (PC_LdEn) begin
                    pc_nxt    = next_pc;
                    valid_nxt = 1'b0;
                    req_nxt   = 1'b1;
                    addr_nxt  = next_pc;
                    wcnt_nxt  = '0;
                    state_nxt = S_WAIT;
                end
            end
            default: begin
                state_nxt = S_FETCH;
            end
        endcase
    end

    assign PC             = pc_q;
    assign Instr          = instr_q;
    assign Instr_Valid    = valid_q;
    assign Fetch_Timeout  = tmo_q;
    assign imem.IMEM_Req  = req_q;
    assign imem.IMEM_Addr = addr_q;

endmodule
